// File: rtl/regfile_wr_decoder.sv
// Registered one-hot write-select decoder for the register file write port, fed by a small request FIFO.
// Optional build macro REGFILE_WR_ZERO_PROTECT_EN makes register 0 read-only (its writes are consumed but never enabled).
module regfile_wr_decoder #(
  parameter int SEL_W      = 5,
  parameter int NUM_OUT    = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [SEL_W-1:0]                req_sel,
  input  logic [DATA_W-1:0]               req_data,
  input  logic                            stall,
  output logic [NUM_OUT-1:0]              wr_en,
  output logic [DATA_W-1:0]               wr_data,
  output logic                            wr_valid,
  output logic                            err_range,
  output logic [$clog2(FIFO_DEPTH):0]     pending
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [SEL_W:0]   NUM_OUT_C = (SEL_W + 1)'(NUM_OUT);

  logic [SEL_W-1:0]  sel_mem  [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              push;
  logic              pop;
  logic [SEL_W-1:0]  head_sel;
  logic [DATA_W-1:0] head_data;
  logic              in_range;
  logic [NUM_OUT-1:0] dec_en;

  // Ready looks only at the registered count, so a same-cycle pop never frees a slot early.
  assign req_ready = (count < DEPTH_C) && !rst;
  assign push      = req_valid && req_ready;
  assign pop       = (count != '0) && !stall;
  assign pending   = count;

  assign head_sel  = sel_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count gates every read, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      sel_mem[wr_ptr]  <= req_sel;
      data_mem[wr_ptr] <= req_data;
    end
  end

  // NOTE: every always_comb output gets a default on its first line, so no path can infer a latch.
  always_comb begin
    dec_en   = '0;
    in_range = ({1'b0, head_sel} < NUM_OUT_C);
    for (int i = 0; i < NUM_OUT; i++) begin
      if (head_sel == SEL_W'(i)) dec_en[i] = 1'b1;
    end
`ifdef REGFILE_WR_ZERO_PROTECT_EN
    if (head_sel == '0) dec_en = '0;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only; the pulse defaults are overridden by a pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en     <= '0;
      wr_data   <= '0;
      wr_valid  <= 1'b0;
      err_range <= 1'b0;
    end else begin
      wr_en     <= '0;
      wr_valid  <= 1'b0;
      err_range <= 1'b0;
      if (pop) begin
        wr_en     <= dec_en;
        wr_data   <= head_data;
        wr_valid  <= 1'b1;
        err_range <= !in_range;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wr_decoder.sv
// Bench for regfile_wr_decoder: a 32-output and a 24-output instance share stimulus and are checked
// against a queue-based model, a hand-written vector table, a walking-select sweep and random traffic.
module tb_regfile_wr_decoder;

`ifdef REGFILE_WR_ZERO_PROTECT_EN
  localparam bit ZP = 1'b1;
`else
  localparam bit ZP = 1'b0;
`endif
  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [4:0]  req_sel;
  logic [31:0] req_data;
  logic        stall;

  logic        ready32, valid32, err32;
  logic [31:0] en32, data32;
  logic [1:0]  pend32;
  logic        ready24, valid24, err24;
  logic [23:0] en24;
  logic [31:0] data24;
  logic [1:0]  pend24;

  regfile_wr_decoder #(.SEL_W(5), .NUM_OUT(32), .DATA_W(32), .FIFO_DEPTH(DEPTH)) dut32 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready32), .req_sel(req_sel),
    .req_data(req_data), .stall(stall), .wr_en(en32), .wr_data(data32), .wr_valid(valid32),
    .err_range(err32), .pending(pend32));

  regfile_wr_decoder #(.SEL_W(5), .NUM_OUT(24), .DATA_W(32), .FIFO_DEPTH(DEPTH)) dut24 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready24), .req_sel(req_sel),
    .req_data(req_data), .stall(stall), .wr_en(en24), .wr_data(data24), .wr_valid(valid24),
    .err_range(err24), .pending(pend24));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of requests plus the expected output pulse.
  typedef struct {
    logic [4:0]  sel;
    logic [31:0] data;
  } req_t;

  req_t        q[$];
  logic [31:0] m_en32, m_en24, m_data;
  logic        m_valid, m_err32, m_err24;

  function automatic logic [31:0] model_en(input int num_out, input logic [4:0] sel);
    if (int'(sel) >= num_out) return 32'h0;
    if (ZP && sel == 5'd0) return 32'h0;
    return 32'h1 << sel;
  endfunction

  task automatic step(input logic r, input logic v, input logic [4:0] s,
                      input logic [31:0] d, input logic st);
    logic exp_ready;
    logic do_push;
    req_t head;
    rst = r; req_valid = v; req_sel = s; req_data = d; stall = st;
    #1;
    exp_ready = !r && (q.size() < DEPTH);
    check("req_ready32", {63'b0, ready32}, {63'b0, exp_ready});
    check("req_ready24", {63'b0, ready24}, {63'b0, exp_ready});
    do_push = v && exp_ready;
    m_en32 = '0; m_en24 = '0; m_valid = 1'b0; m_err32 = 1'b0; m_err24 = 1'b0;
    if (r) begin
      q.delete();
      m_data = '0;
    end else begin
      if (q.size() > 0 && !st) begin
        head    = q.pop_front();
        m_valid = 1'b1;
        m_data  = head.data;
        m_en32  = model_en(32, head.sel);
        m_en24  = model_en(24, head.sel);
        m_err32 = 1'b0;
        m_err24 = (int'(head.sel) >= 24);
      end
      if (do_push) q.push_back('{sel: s, data: d});
    end
    @(posedge clk);
    @(negedge clk);
    check("wr_en32",     {32'b0, en32},          {32'b0, m_en32});
    check("wr_en24",     {40'b0, en24},          {32'b0, m_en24});
    check("wr_valid32",  {63'b0, valid32},       {63'b0, m_valid});
    check("wr_valid24",  {63'b0, valid24},       {63'b0, m_valid});
    check("err_range32", {63'b0, err32},         {63'b0, m_err32});
    check("err_range24", {63'b0, err24},         {63'b0, m_err24});
    check("pending32",   {62'b0, pend32},        64'(q.size()));
    check("pending24",   {62'b0, pend24},        64'(q.size()));
    if (m_valid) begin
      check("wr_data32", {32'b0, data32}, {32'b0, m_data});
      check("wr_data24", {32'b0, data24}, {32'b0, m_data});
    end
  endtask

  // Hand-computed vectors: inputs for one cycle, ready before the edge, outputs after it.
  typedef struct {
    logic        r, v, st;
    logic [4:0]  sel;
    logic [31:0] data;
    logic        ready;
    logic [31:0] en32, en24;
    logic        valid, err24;
    logic [31:0] dat;
    int          pend;
  } vec_t;

  function automatic vec_t mk(input logic r, v, st, input logic [4:0] sel, input logic [31:0] data,
                              input logic ready, input logic [31:0] e32, e24, input logic valid,
                              input logic err, input logic [31:0] dat, input int pend);
    vec_t t;
    t.r = r; t.v = v; t.st = st; t.sel = sel; t.data = data; t.ready = ready;
    t.en32 = e32; t.en24 = e24; t.valid = valid; t.err24 = err; t.dat = dat; t.pend = pend;
    return t;
  endfunction

  vec_t tbl[20];

  initial begin
    logic [31:0] zp_en;
    rst = 1'b1; req_valid = 1'b0; req_sel = '0; req_data = '0; stall = 1'b0;
    m_data = '0;
    zp_en = ZP ? 32'h0 : 32'h1;

    //            r  v  st sel    data          rdy en32          en24        vld err dat           pend
    tbl[0]  = mk(1, 0, 0, 5'd0,  32'h0,        0, 32'h0,        32'h0,      0, 0, 32'h0,        0);
    tbl[1]  = mk(0, 1, 0, 5'd5,  32'hDEADBEEF, 1, 32'h0,        32'h0,      0, 0, 32'h0,        1);
    tbl[2]  = mk(0, 0, 0, 5'd0,  32'h0,        1, 32'h20,       32'h20,     1, 0, 32'hDEADBEEF, 0);
    tbl[3]  = mk(0, 0, 0, 5'd0,  32'h0,        1, 32'h0,        32'h0,      0, 0, 32'h0,        0);
    tbl[4]  = mk(0, 1, 1, 5'd1,  32'h1,        1, 32'h0,        32'h0,      0, 0, 32'h0,        1);
    tbl[5]  = mk(0, 1, 1, 5'd2,  32'h2,        1, 32'h0,        32'h0,      0, 0, 32'h0,        2);
    tbl[6]  = mk(0, 1, 1, 5'd3,  32'h3,        0, 32'h0,        32'h0,      0, 0, 32'h0,        2);
    tbl[7]  = mk(0, 1, 1, 5'd3,  32'h3,        0, 32'h0,        32'h0,      0, 0, 32'h0,        2);
    tbl[8]  = mk(0, 1, 0, 5'd3,  32'h3,        0, 32'h2,        32'h2,      1, 0, 32'h1,        1);
    tbl[9]  = mk(0, 1, 0, 5'd3,  32'h3,        1, 32'h4,        32'h4,      1, 0, 32'h2,        1);
    tbl[10] = mk(0, 0, 0, 5'd0,  32'h0,        1, 32'h8,        32'h8,      1, 0, 32'h3,        0);
    tbl[11] = mk(0, 1, 0, 5'd30, 32'hA5,       1, 32'h0,        32'h0,      0, 0, 32'h0,        1);
    tbl[12] = mk(0, 1, 0, 5'd3,  32'h33,       1, 32'h40000000, 32'h0,      1, 1, 32'hA5,       1);
    tbl[13] = mk(0, 0, 0, 5'd0,  32'h0,        1, 32'h8,        32'h8,      1, 0, 32'h33,       0);
    tbl[14] = mk(0, 1, 1, 5'd7,  32'h77,       1, 32'h0,        32'h0,      0, 0, 32'h0,        1);
    tbl[15] = mk(0, 1, 1, 5'd8,  32'h88,       1, 32'h0,        32'h0,      0, 0, 32'h0,        2);
    tbl[16] = mk(1, 0, 0, 5'd0,  32'h0,        0, 32'h0,        32'h0,      0, 0, 32'h0,        0);
    tbl[17] = mk(0, 0, 0, 5'd0,  32'h0,        1, 32'h0,        32'h0,      0, 0, 32'h0,        0);
    tbl[18] = mk(0, 1, 0, 5'd0,  32'h1234,     1, 32'h0,        32'h0,      0, 0, 32'h0,        1);
    tbl[19] = mk(0, 0, 0, 5'd0,  32'h0,        1, zp_en,        zp_en,      1, 0, 32'h1234,     0);

    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].sel, tbl[i].data, tbl[i].st);
      check($sformatf("tbl%0d_en32", i),  {32'b0, en32},       {32'b0, tbl[i].en32});
      check($sformatf("tbl%0d_en24", i),  {40'b0, en24},       {32'b0, tbl[i].en24});
      check($sformatf("tbl%0d_valid", i), {63'b0, valid32},    {63'b0, tbl[i].valid});
      check($sformatf("tbl%0d_err24", i), {63'b0, err24},      {63'b0, tbl[i].err24});
      check($sformatf("tbl%0d_pend", i),  {62'b0, pend32},     64'(tbl[i].pend));
      if (tbl[i].valid)
        check($sformatf("tbl%0d_data", i), {32'b0, data32}, {32'b0, tbl[i].dat});
    end

    // Walking select, one request per cycle with no stall: wr_en must move one bit per cycle.
    for (int i = 0; i < 32; i++) begin
      step(0, 1, 5'(i), 32'h1000 + 32'(i), 0);
      if (i > 0) check($sformatf("walk%0d", i - 1), {32'b0, en32}, {32'b0, model_en(32, 5'(i - 1))});
    end
    step(0, 0, 5'd0, 32'h0, 0);
    check("walk_last", {32'b0, en32}, 64'h80000000);
    step(0, 0, 5'd0, 32'h0, 0);

    // Random traffic with occasional stalls and resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
           $urandom(), ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
